playseq_sequenciador_preview: RTL and testbench
===============================================

Name: playseq_sequenciador_preview

Overview:
- Controller that plays back the stored PlaySeq sequence on the LEDs before each round.
- Reads the sequence memory from address 0 to a programmed last index.
- Holds each value on the LEDs for a level-dependent on-time, followed by a fixed dark gap.
- Sits between the game control unit (start/fim handshake) and the sequence memory plus LED drivers, replacing ad-hoc LED timing inside the control unit.

Parameters:
ADDR_W, 4, width of sequence memory address and last-index input
CNT_W, 12, width of internal cycle counter
ON_SLOW, 1000, LED on-time in clock cycles at nivel=00; must fit CNT_W; ON_SLOW>>3 must be ≥1
GAP, 250, LED-off cycles between consecutive values; ≥1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request playback; sampled only in ocioso
abort  in  1  cancel playback; synchronous, highest priority after reset
nivel  in  2  speed level, latched at start
ultimo  in  ADDR_W  index of last element to show, latched at start
mem_dado  in  4  sequence memory read data for mem_endereco (combinational, valid the same cycle)
mem_endereco  out  ADDR_W  sequence memory read address
leds  out  4  LED drive, one-hot or zero
ocupado  out  1  high in every state except ocioso
fim  out  1  one-cycle pulse when playback completes normally
db_estado  out  4  state code for debug display

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset (reset=0, asynchronous) forces:
  - state = ocioso
  - mem_endereco = 0, leds = 0, ocupado = 0, fim = 0, db_estado = 0
  - counter = 0, latched nivel/ultimo = 0
- States and db_estado codes: ocioso 0, carrega 1, acende 2, apaga 3, avanca 4, conclui 5. Unused codes go to ocioso, db_estado = F.
- ocioso:
  - On start=1 (and abort=0): latch nivel and ultimo, set mem_endereco = 0, go to carrega.
  - Otherwise remain.
- carrega: exactly 1 cycle; memory settles. Go to acende, load leds ← mem_dado, clear counter.
- acende:
  - leds hold the loaded value.
  - Counter increments each cycle.
  - When counter = T_on−1: go to apaga, leds ← 0, clear counter.
  - T_on = ON_SLOW >> nivel_latched (00: ON_SLOW, 01: /2, 10: /4, 11: /8). acende lasts exactly T_on cycles.
- apaga:
  - leds = 0; counter counts.
  - When counter = GAP−1: go to conclui if mem_endereco == ultimo_latched, else avanca. apaga lasts exactly GAP cycles.
- avanca: 1 cycle; mem_endereco ← mem_endereco+1; go to carrega.
- conclui: 1 cycle; fim = 1; mem_endereco ← 0; go to ocioso. fim is never asserted in any other state.
- abort=1 in any non-ocioso state:
  - Next state is ocioso; leds ← 0, mem_endereco ← 0, counter ← 0.
  - No fim pulse.
  - abort beats counter expiry in the same cycle.
- abort=1 in ocioso: no effect, and it blocks start in that cycle.
- start while ocupado=1 is ignored; no queuing.
- nivel/ultimo changes during playback have no effect until the next start.
- ultimo=0: one element shown, then conclui.
- ultimo = 2^ADDR_W−1: full memory shown; the address never wraps because conclui is taken before avanca.
- mem_dado = 0: leds dark for the on-time; still counts as an element.
- Total latency, start sample to fim pulse: (ultimo+1)·(1+T_on+GAP) + ultimo + 1 cycles.
  - Per element: carrega + acende + apaga.
  - Plus ultimo avanca cycles.
  - Plus the conclui cycle in which fim is high.
- Mid-operation reset behaves as at power-up; no residual fim.

Test Plan (ON_SLOW=8, GAP=2, ADDR_W=4; memory model 0:0001, 1:0010, 2:0100, 3:1000):
- Reset then idle: reset=0 for 3 cycles, release -> leds=0, ocupado=0, fim=0, db_estado=0, mem_endereco=0; start=0 keeps ocioso.
- Full playback, nivel=00, ultimo=3:
  - leds show 0001 for 8 cycles, 0 for 2, then 0010, 0100, 1000 in turn.
  - mem_endereco steps 0→3.
  - fim pulses once, 4·11+4 = 48 cycles after start; ocupado falls the next cycle.
- Speed levels, ultimo=0:
  - nivel=01: acende lasts 4 cycles.
  - nivel=11: acende lasts 1 cycle.
  - fim arrives at 1+T_on+2+1 cycles.
  - Changing nivel mid-run does not alter timing.
- Abort mid-acende of element 2:
  - Next cycle: ocioso, leds=0, mem_endereco=0, no fim ever.
  - A new start replays from element 0.
- Start during playback and start with abort: a second start pulse while ocupado=1 does not restart; start=1 with abort=1 in ocioso stays ocioso.
- Async reset during apaga of element 1: outputs go to reset values immediately, without waiting for a clock edge; no fim after release.

Source files
------------

// File: rtl/playseq_sequenciador_preview.sv
// Plays the stored sequence on the LEDs before each round: address 0..ultimo,
// each value lit for a level-dependent on-time followed by a fixed dark gap.
module playseq_sequenciador_preview #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned ON_SLOW = 1000,
    parameter int unsigned GAP     = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        nivel,
    input  logic [ADDR_W-1:0] ultimo,
    input  logic [3:0]        mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [3:0]        leds,
    output logic              ocupado,
    output logic              fim,
    output logic [3:0]        db_estado
);

    typedef enum logic [2:0] {
        Ocioso  = 3'd0,
        Carrega = 3'd1,
        Acende  = 3'd2,
        Apaga   = 3'd3,
        Avanca  = 3'd4,
        Conclui = 3'd5
    } estado_t;

    estado_t           r_estado, w_estado_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [1:0]        r_nivel, w_nivel_d;
    logic [ADDR_W-1:0] r_ultimo, w_ultimo_d;
    logic [ADDR_W-1:0] r_endereco, w_endereco_d;
    logic [3:0]        r_leds, w_leds_d;
    logic [CNT_W-1:0]  w_on_last;
    logic [CNT_W-1:0]  w_gap_last;
    logic [3:0]        w_db;

    // Last count value of each timed phase; on-time shrinks by a power of two per level.
    assign w_on_last  = CNT_W'(ON_SLOW >> r_nivel) - CNT_W'(1);
    assign w_gap_last = CNT_W'(GAP - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= Ocioso;
            r_cnt      <= '0;
            r_nivel    <= '0;
            r_ultimo   <= '0;
            r_endereco <= '0;
            r_leds     <= '0;
        end else begin
            r_estado   <= w_estado_d;
            r_cnt      <= w_cnt_d;
            r_nivel    <= w_nivel_d;
            r_ultimo   <= w_ultimo_d;
            r_endereco <= w_endereco_d;
            r_leds     <= w_leds_d;
        end
    end

    always_comb begin
        w_estado_d   = r_estado;
        w_cnt_d      = r_cnt;
        w_nivel_d    = r_nivel;
        w_ultimo_d   = r_ultimo;
        w_endereco_d = r_endereco;
        w_leds_d     = r_leds;
        if (abort && (r_estado != Ocioso)) begin
            w_estado_d   = Ocioso;
            w_cnt_d      = '0;
            w_endereco_d = '0;
            w_leds_d     = '0;
        end else begin
            case (r_estado)
                Ocioso: begin
                    if (start && !abort) begin
                        w_nivel_d    = nivel;
                        w_ultimo_d   = ultimo;
                        w_endereco_d = '0;
                        w_estado_d   = Carrega;
                    end
                end
                Carrega: begin
                    w_leds_d   = mem_dado;
                    w_cnt_d    = '0;
                    w_estado_d = Acende;
                end
                Acende: begin
                    if (r_cnt == w_on_last) begin
                        w_leds_d   = '0;
                        w_cnt_d    = '0;
                        w_estado_d = Apaga;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                Apaga: begin
                    if (r_cnt == w_gap_last) begin
                        w_cnt_d    = '0;
                        w_estado_d = (r_endereco == r_ultimo) ? Conclui : Avanca;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                Avanca: begin
                    w_endereco_d = r_endereco + ADDR_W'(1);
                    w_estado_d   = Carrega;
                end
                Conclui: begin
                    w_endereco_d = '0;
                    w_estado_d   = Ocioso;
                end
                default: begin
                    w_estado_d   = Ocioso;
                    w_cnt_d      = '0;
                    w_endereco_d = '0;
                    w_leds_d     = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_db = 4'hF;
        case (r_estado)
            Ocioso:  w_db = 4'h0;
            Carrega: w_db = 4'h1;
            Acende:  w_db = 4'h2;
            Apaga:   w_db = 4'h3;
            Avanca:  w_db = 4'h4;
            Conclui: w_db = 4'h5;
            default: w_db = 4'hF;
        endcase
    end

    assign mem_endereco = r_endereco;
    assign leds         = r_leds;
    assign ocupado      = (r_estado != Ocioso);
    assign fim          = (r_estado == Conclui);
    assign db_estado    = w_db;

endmodule

// File: tb/tb_playseq_sequenciador_preview.sv
// Scoreboard bench: each accepted start queues the expected per-cycle LED trace,
// a negedge monitor pops and compares; an empty queue means the idle outputs.
module tb_playseq_sequenciador_preview;

    localparam int ON_SLOW = 8;
    localparam int GAP     = 2;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] nivel;
    logic [3:0] ultimo;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] addr;
        logic       ocup;
        logic       fim;
        logic [3:0] db;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    playseq_sequenciador_preview #(
        .ADDR_W (4),
        .CNT_W  (12),
        .ON_SLOW(ON_SLOW),
        .GAP    (GAP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nivel       (nivel),
        .ultimo      (ultimo),
        .mem_dado    (mem_dado),
        .mem_endereco(mem_endereco),
        .leds        (leds),
        .ocupado     (ocupado),
        .fim         (fim),
        .db_estado   (db_estado)
    );

    assign mem_dado = mem[mem_endereco];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic exp_t mk(input logic [3:0] l, input logic [3:0] a, input logic o,
                                input logic f, input logic [3:0] d);
        exp_t e;
        e.leds = l;
        e.addr = a;
        e.ocup = o;
        e.fim  = f;
        e.db   = d;
        return e;
    endfunction

    // Monitor: one comparison per clock, against the queued trace or the idle state.
    always @(negedge clock) begin
        exp_t e;
        exp_t g;
        if (q.size() > 0) e = q.pop_front();
        else e = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        g = mk(leds, mem_endereco, ocupado, fim, db_estado);
        n_chk++;
        if (g !== e) begin
            n_err++;
            $display("FAIL trace t=%0t got leds=%b addr=%0d ocup=%b fim=%b db=%0h exp leds=%b addr=%0d ocup=%b fim=%b db=%0h",
                     $time, g.leds, g.addr, g.ocup, g.fim, g.db,
                     e.leds, e.addr, e.ocup, e.fim, e.db);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected playback: per element one load cycle, on-time lit, gap dark, then
    // an advance cycle between elements and a final done cycle with fim high.
    task automatic push_trace(input logic [1:0] nv, input logic [3:0] ul);
        int t_on;
        t_on = ON_SLOW >> nv;
        for (int i = 0; i <= int'(ul); i++) begin
            q.push_back(mk(4'h0, 4'(i), 1'b1, 1'b0, 4'h1));
            for (int c = 0; c < t_on; c++) q.push_back(mk(mem[i], 4'(i), 1'b1, 1'b0, 4'h2));
            for (int c = 0; c < GAP; c++) q.push_back(mk(4'h0, 4'(i), 1'b1, 1'b0, 4'h3));
            if (i < int'(ul)) q.push_back(mk(4'h0, 4'(i), 1'b1, 1'b0, 4'h4));
        end
        q.push_back(mk(4'h0, ul, 1'b1, 1'b1, 4'h5));
    endtask

    task automatic play(input logic [1:0] nv, input logic [3:0] ul);
        start  = 1'b1;
        nivel  = nv;
        ultimo = ul;
        @(posedge clock);
        #1;
        start  = 1'b0;
        push_trace(nv, ul);
        nivel  = 2'($urandom);
        ultimo = 4'($urandom);
    endtask

    // Drain the queue while scrambling nivel/ultimo; bounded so a stuck run still ends.
    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clock);
            #1;
            nivel  = 2'($urandom);
            ultimo = 4'($urandom);
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL timeout got=%0d pending exp=0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic abort_at(input int k);
        repeat (k) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        q.delete();
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] vals [5];
        int         len;
        vals[0] = 4'h0; vals[1] = 4'h1; vals[2] = 4'h2; vals[3] = 4'h4; vals[4] = 4'h8;
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
        start  = 1'b0;
        abort  = 1'b0;
        nivel  = 2'd0;
        ultimo = 4'd0;
        reset  = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Full playback, then the speed levels with a single element.
        play(2'd0, 4'd3);
        wait_done();
        play(2'd1, 4'd0);
        wait_done();
        play(2'd3, 4'd0);
        wait_done();
        play(2'd2, 4'd1);
        wait_done();

        // Abort during element 2 lit phase, then replay from element 0.
        play(2'd0, 4'd3);
        abort_at(27);
        play(2'd0, 4'd3);
        wait_done();

        // Second start while busy is ignored.
        play(2'd1, 4'd2);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done();

        // start together with abort while idle does nothing.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // Asynchronous reset during the gap of element 1, checked before any edge.
        play(2'd0, 4'd3);
        repeat (21) @(posedge clock);
        #2;
        reset = 1'b0;
        q.delete();
        #1;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_ocupado", 32'(ocupado), 32'h0);
        chk("rst_fim", 32'(fim), 32'h0);
        chk("rst_db", 32'(db_estado), 32'h0);
        chk("rst_addr", 32'(mem_endereco), 32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (60) @(posedge clock);
        #1;

        // Full 16-entry memory at the fastest level.
        for (int i = 0; i < 16; i++) mem[i] = vals[$urandom_range(4, 0)];
        play(2'd3, 4'd15);
        wait_done();

        // Randomized playbacks, some aborted part-way.
        for (int r = 0; r < 12; r++) begin
            logic [1:0] nv;
            logic [3:0] ul;
            for (int i = 0; i < 16; i++) mem[i] = vals[$urandom_range(4, 0)];
            nv = 2'($urandom);
            ul = 4'($urandom_range(6, 0));
            play(nv, ul);
            len = q.size();
            if ($urandom_range(2, 0) == 0) abort_at($urandom_range(len - 1, 0));
            else wait_done();
        end

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
